// File: rtl/quad_encoder_speed.sv
// Quadrature encoder front end for the PID speed loop: x4 edge decode, per-window
// speed magnitude/direction with saturation, and a free-running signed position count.
module quad_encoder_speed #(
  parameter int WINDOW_CYCLES = 100000,
  parameter int CNT_W         = 16,
  parameter int FEED_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enc_a,
  input  logic              enc_b,
  output logic [FEED_W-1:0] feed,
  output logic              dir,
  output logic              feed_valid,
  output logic              feed_sat,
  output logic              quad_err,
  output logic [CNT_W-1:0]  position
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam int SW    = CNT_W + 1;
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic signed [SW-1:0] ACC_MAX  = SW'((1 << (CNT_W - 1)) - 1);
  localparam logic signed [SW-1:0] ACC_MIN  = -ACC_MAX;
  localparam logic [SW-1:0]        FEED_MAX = SW'((1 << FEED_W) - 1);

  logic [1:0]              s1, s2, prev;
  logic [1:0]              ord_prev, ord_cur, delta;
  logic                    illegal;
  logic signed [SW-1:0]    step, total, acc_sat;
  logic [SW-1:0]           mag;
  logic [WIN_W-1:0]        win;
  logic signed [CNT_W-1:0] acc;

  // Gray state -> position along 00,01,11,10; the modulo-4 difference is the step.
  always_comb begin
    ord_prev = {prev[1], prev[1] ^ prev[0]};
    ord_cur  = {s2[1], s2[1] ^ s2[0]};
    delta    = ord_cur - ord_prev;
    illegal  = (delta == 2'd2);
    step     = '0;
    case (delta)
      2'd1:    step = SW'(1);
      2'd3:    step = '1;
      default: step = '0;
    endcase
    total = {acc[CNT_W-1], acc} + step;
    if (total > ACC_MAX)      acc_sat = ACC_MAX;
    else if (total < ACC_MIN) acc_sat = ACC_MIN;
    else                      acc_sat = total;
    mag = total[SW-1] ? $unsigned(-total) : $unsigned(total);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1         <= '0;
      s2         <= '0;
      prev       <= '0;
      win        <= '0;
      acc        <= '0;
      feed       <= '0;
      dir        <= 1'b0;
      feed_valid <= 1'b0;
      feed_sat   <= 1'b0;
      quad_err   <= 1'b0;
      position   <= '0;
    end else begin
      s1         <= {enc_a, enc_b};
      s2         <= s1;
      prev       <= s2;
      quad_err   <= illegal;
      position   <= position + step[CNT_W-1:0];
      feed_valid <= 1'b0;
      if (win == WIN_LAST) begin
        // The boundary-cycle step is folded into the closing window's total.
        win        <= '0;
        acc        <= '0;
        feed_valid <= 1'b1;
        dir        <= total[SW-1];
        feed_sat   <= (mag > FEED_MAX);
        feed       <= (mag > FEED_MAX) ? '1 : mag[FEED_W-1:0];
      end else begin
        win <= win + 1'b1;
        acc <= acc_sat[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_speed.sv
// Randomized and directed bench for quad_encoder_speed: two window lengths driven from
// the same encoder pins, checked every cycle against an arithmetic model.
module tb_quad_encoder_speed;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enc_a = 1'b0, enc_b = 1'b0;
  logic [1:0] ab = 2'b00;
  always #5 clk = ~clk;

  logic [7:0]  f0, f1;
  logic        d0, d1, v0, v1, s0, s1, e0, e1;
  logic [15:0] p0, p1;

  quad_encoder_speed #(.WINDOW_CYCLES(100), .CNT_W(16), .FEED_W(8)) dut0 (
    .clk(clk), .reset(rst_n), .enc_a(enc_a), .enc_b(enc_b), .feed(f0), .dir(d0),
    .feed_valid(v0), .feed_sat(s0), .quad_err(e0), .position(p0));
  quad_encoder_speed #(.WINDOW_CYCLES(300), .CNT_W(16), .FEED_W(8)) dut1 (
    .clk(clk), .reset(rst_n), .enc_a(enc_a), .enc_b(enc_b), .feed(f1), .dir(d1),
    .feed_valid(v1), .feed_sat(s1), .quad_err(e1), .position(p1));

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int W[2] = '{100, 300};
  int m_cyc[2], m_acc[2], m_feed[2], m_dir[2], m_vld[2], m_sat[2], m_pos[2];
  int m_err;
  logic [1:0] q0, q1, q2;   // pin values seen at the last three clock edges

  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int d, st, tot, mag;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_cyc[i] = 0; m_acc[i] = 0; m_feed[i] = 0; m_dir[i] = 0;
        m_vld[i] = 0; m_sat[i] = 0; m_pos[i] = 0;
      end
      m_err = 0; q0 = 0; q1 = 0; q2 = 0;
    end else begin
      // A pin change is counted on the third edge after it appears.
      d  = (gidx(q1) - gidx(q2) + 4) % 4;
      st = (d == 1) ? 1 : (d == 3) ? -1 : 0;
      m_err = (d == 2);
      for (int i = 0; i < 2; i++) begin
        tot = m_acc[i] + st;
        m_pos[i] = (m_pos[i] + st + 65536) % 65536;
        if (m_cyc[i] % W[i] == W[i] - 1) begin
          mag = (tot < 0) ? -tot : tot;
          m_vld[i]  = 1;
          m_dir[i]  = (tot < 0);
          m_feed[i] = (mag > 255) ? 255 : mag;
          m_sat[i]  = (mag > 255);
          m_acc[i]  = 0;
        end else begin
          m_vld[i] = 0;
          m_acc[i] = (tot > 32767) ? 32767 : (tot < -32767) ? -32767 : tot;
        end
        m_cyc[i]++;
      end
      q2 = q1; q1 = q0; q0 = {enc_a, enc_b};
    end
  end

  // ---------------- per-cycle compare + strobe capture ----------------
  int ncyc = 0;
  int nstb[2], lst_feed[2], lst_dir[2], lst_sat[2], lst_pos[2], prv_pos[2], lst_t[2], prv_t[2];
  initial for (int i = 0; i < 2; i++) begin
    nstb[i] = 0; lst_feed[i] = 0; lst_dir[i] = 0; lst_sat[i] = 0;
    lst_pos[i] = 0; prv_pos[i] = 0; lst_t[i] = 0; prv_t[i] = 0;
  end

  always @(negedge clk) begin
    int af, ad, av, as, ae, ap;
    ncyc++;
    for (int i = 0; i < 2; i++) begin
      af = (i == 0) ? int'(f0) : int'(f1);
      ad = (i == 0) ? int'(d0) : int'(d1);
      av = (i == 0) ? int'(v0) : int'(v1);
      as = (i == 0) ? int'(s0) : int'(s1);
      ae = (i == 0) ? int'(e0) : int'(e1);
      ap = (i == 0) ? int'(p0) : int'(p1);
      chk($sformatf("feed%0d", i), af, m_feed[i]);
      chk($sformatf("dir%0d", i), ad, m_dir[i]);
      chk($sformatf("valid%0d", i), av, m_vld[i]);
      chk($sformatf("sat%0d", i), as, m_sat[i]);
      chk($sformatf("qerr%0d", i), ae, m_err);
      chk($sformatf("pos%0d", i), ap, m_pos[i]);
      if (av == 1) begin
        nstb[i]++;
        lst_feed[i] = af; lst_dir[i] = ad; lst_sat[i] = as;
        prv_pos[i] = lst_pos[i]; lst_pos[i] = ap;
        prv_t[i] = lst_t[i]; lst_t[i] = ncyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [1:0] v);
    ab = v; enc_a = v[1]; enc_b = v[0];
  endtask

  function automatic logic [1:0] nxt(input logic [1:0] v, input bit rev);
    if (!rev) case (v) 2'b00: return 2'b01; 2'b01: return 2'b11; 2'b11: return 2'b10; default: return 2'b00; endcase
    else      case (v) 2'b00: return 2'b10; 2'b10: return 2'b11; 2'b11: return 2'b01; default: return 2'b00; endcase
  endfunction

  task automatic run(input int n, input int per, input bit rev);
    repeat (n / per) begin
      drive(nxt(ab, rev));
      repeat (per) @(negedge clk);
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_feed0"}, int'(f0), 0); chk({tag, "_dir0"}, int'(d0), 0);
    chk({tag, "_valid0"}, int'(v0), 0); chk({tag, "_sat0"}, int'(s0), 0);
    chk({tag, "_qerr0"}, int'(e0), 0); chk({tag, "_pos0"}, int'(p0), 0);
    chk({tag, "_feed1"}, int'(f1), 0); chk({tag, "_pos1"}, int'(p1), 0);
  endtask

  initial begin
    int ppos, n;
    bit found;
    #1 outs_zero("reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Stationary: two empty windows 100 cycles apart.
    repeat (205) @(negedge clk);
    #1;
    chk("idle_strobes", nstb[0], 2);
    chk("idle_feed", lst_feed[0], 0);
    chk("idle_spacing", lst_t[0] - prv_t[0], 100);

    // Forward, one step per 10 clk.
    run(400, 10, 1'b0);
    #1;
    chk("fwd_feed", lst_feed[0], 10);
    chk("fwd_dir", lst_dir[0], 0);
    chk("fwd_sat", lst_sat[0], 0);
    chk("fwd_spacing", lst_t[0] - prv_t[0], 100);

    // Reverse, same rate.
    run(400, 10, 1'b1);
    #1;
    chk("rev_feed", lst_feed[0], 10);
    chk("rev_dir", lst_dir[0], 1);
    chk("rev_pos_drop", (prv_pos[0] - lst_pos[0]) & 16'hFFFF, 10);

    // One step per clock: 300 edges saturate the long window.
    run(700, 1, 1'b0);
    #1;
    chk("fast_feed1", lst_feed[1], 255);
    chk("fast_sat1", lst_sat[1], 1);
    chk("fast_dir1", lst_dir[1], 0);
    chk("fast_feed0", lst_feed[0], 100);
    chk("fast_sat0", lst_sat[0], 0);

    // Illegal 00 -> 11 transition.
    while (ab != 2'b00) begin
      drive(nxt(ab, 1'b0));
      repeat (5) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    #1 ppos = int'(p0);
    drive(2'b11);
    @(negedge clk); #1 chk("qerr_edge1", int'(e0), 0);
    @(negedge clk); #1 chk("qerr_edge2", int'(e0), 0);
    @(negedge clk); #1 chk("qerr_edge3", int'(e0), 1);
    @(negedge clk); #1 chk("qerr_edge4", int'(e0), 0);
    repeat (5) @(negedge clk);
    #1 chk("qerr_pos_hold", int'(p0), ppos);

    // Randomized mix of forward, reverse, hold and illegal moves.
    repeat (400) begin
      n = $urandom_range(0, 9);
      if (n < 4)      drive(nxt(ab, 1'b0));
      else if (n < 7) drive(nxt(ab, 1'b1));
      else if (n == 9) drive(ab ^ 2'b11);
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end

    // Reset in the middle of a window.
    repeat (5) begin
      drive(nxt(ab, 1'b0));
      repeat (4) @(negedge clk);
    end
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (m_cyc[0] % 100 == 50) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("reach_win50", int'(found), 1);
    #2 rst_n = 1'b0;
    #1 outs_zero("midreset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1 chk("restart_pos", int'(p0), 0);
    n = 1;
    while (v0 !== 1'b1 && n < 250) begin
      @(negedge clk);
      #1 n++;
    end
    chk("restart_first_strobe", n, 100);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
